score_event_serializer: RTL and testbench

- Upstream feeder of the four-digit score display.
- Accepts point-award events from game logic into a small FIFO.
- Serializes each award into single-point transitions on score_signal; the display adds one per edge, either polarity.
- Owns the round timer and drives game_end, which the display uses to clear its digits.

---
 rtl/score_event_serializer.sv | 196 +++++++++++++++++++
 tb/tb_score_event_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_event_serializer.sv
// Point-award FIFO, single-point score_signal serializer and round timer for the score display.
// Optional macro HIT_COMBO_EN: awards accepted within COMBO_WINDOW ticks of the last nonzero award are doubled.
module score_event_serializer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 8,
    parameter int TICK_DIV     = 50000000,
    parameter int GAME_TICKS   = 60,
    parameter int COMBO_WINDOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit_valid,
    input  logic [3:0] hit_points,
    output logic       hit_ready,
    output logic       score_signal,
    output logic [3:0] get_score,
    output logic       game_end,
    output logic       busy,
    output logic [7:0] time_left
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMR_W = $clog2(GAME_TICKS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GAME_TICKS);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       TL_IDLE  = (GAME_TICKS > 255) ? 8'd255 : 8'(GAME_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic              active_q, active_d;
    logic [3:0]        rem_q, rem_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              sig_q, sig_d;
    logic [3:0]        gs_q, gs_d;
    logic [3:0]        mem_q [FIFO_DEPTH];

    logic       empty, full, push, tick, enter_run, end_entry;
    logic [3:0] head, push_data;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head      = mem_q[rd_q[AW-1:0]];
    assign tick      = (state_q == S_RUN) && (div_q == DIV_MAX);
    assign enter_run = (state_q != S_RUN) && start;
    assign end_entry = tick && (timer_q == TMR_W'(1));
    assign hit_ready = (state_q == S_RUN) && !full;
    assign push      = hit_valid && hit_ready && !end_entry;

`ifdef HIT_COMBO_EN
    localparam int AGE_W = $clog2(COMBO_WINDOW + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(COMBO_WINDOW + 1);

    logic             combo_vld_q, combo_vld_d;
    logic [AGE_W-1:0] age_q, age_d;

    function automatic logic [3:0] sat_double(input logic [3:0] p);
        logic [4:0] d;
        d = {p, 1'b0};
        return (d > 5'd15) ? 4'd15 : d[3:0];
    endfunction

    assign push_data = (combo_vld_q && (age_q < AGE_MAX)) ? sat_double(hit_points) : hit_points;

    // Age counts ticks since the last nonzero accept and saturates just past the window.
    always_comb begin
        combo_vld_d = combo_vld_q;
        age_d       = age_q;
        if (tick && (age_q != AGE_MAX)) age_d = age_q + AGE_W'(1);
        if (push && (hit_points != 4'd0)) begin
            combo_vld_d = 1'b1;
            age_d       = '0;
        end
        if (enter_run) begin
            combo_vld_d = 1'b0;
            age_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            combo_vld_q <= 1'b0;
            age_q       <= '0;
        end else begin
            combo_vld_q <= combo_vld_d;
            age_q       <= age_d;
        end
    end
`else
    assign push_data = hit_points;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        timer_d  = timer_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        active_d = active_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        sig_d    = sig_q;
        gs_d     = gs_q;
        if (push) wr_d = wr_q + PW'(1);
        case (state_q)
            S_RUN: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) timer_d = timer_q - TMR_W'(1);
                // An award stays active through the trailing gap so the next pop keeps edge spacing.
                if (active_q && (gap_q != '0)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (active_q && (rem_q != 4'd0)) begin
                    sig_d = ~sig_q;
                    rem_d = rem_q - 4'd1;
                    gap_d = GAP_LOAD;
                end else if (!empty) begin
                    rd_d     = rd_q + PW'(1);
                    rem_d    = head;
                    gs_d     = head;
                    active_d = (head != 4'd0);
                    gap_d    = '0;
                end else begin
                    active_d = 1'b0;
                end
                if (end_entry) begin
                    state_d  = S_END;
                    wr_d     = '0;
                    rd_d     = '0;
                    active_d = 1'b0;
                    rem_d    = 4'd0;
                    gap_d    = '0;
                    sig_d    = sig_q;
                    gs_d     = gs_q;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    timer_d = TMR_LOAD;
                    div_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            timer_q  <= TMR_LOAD;
            wr_q     <= '0;
            rd_q     <= '0;
            active_q <= 1'b0;
            rem_q    <= 4'd0;
            gap_q    <= '0;
            sig_q    <= 1'b0;
            gs_q     <= 4'd0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            timer_q  <= timer_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            active_q <= active_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            sig_q    <= sig_d;
            gs_q     <= gs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    always_comb begin
        case (state_q)
            S_RUN:   time_left = (32'(timer_q) > 32'd255) ? 8'd255 : 8'(timer_q);
            S_END:   time_left = 8'd0;
            default: time_left = TL_IDLE;
        endcase
    end

    assign score_signal = sig_q;
    assign get_score    = gs_q;
    assign game_end     = (state_q == S_END);
    assign busy         = active_q || !empty;

endmodule

// File: tb/tb_score_event_serializer.sv
// Directed bench for score_event_serializer: a long-round instance for serialization and a
// short-round instance (TICK_DIV=4, GAME_TICKS=2) for end-of-round behaviour.
module tb_score_event_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, hit_valid;
    logic [3:0] hit_points;
    logic       hit_ready, score_signal, game_end, busy;
    logic [3:0] get_score;
    logic [7:0] time_left;

    logic       s_rst, s_start, s_hit_valid;
    logic [3:0] s_hit_points;
    logic       s_hit_ready, s_score_signal, s_game_end, s_busy;
    logic [3:0] s_get_score;
    logic [7:0] s_time_left;

    int checks = 0;
    int errors = 0;

`ifdef HIT_COMBO_EN
    localparam int EXP_ZERO_PTS  = 4;
    localparam int EXP_FULL_TOG  = 9;
    localparam int EXP_COMBO_TOG = 19;
    localparam int EXP_COMBO_GS  = 15;
`else
    localparam int EXP_ZERO_PTS  = 2;
    localparam int EXP_FULL_TOG  = 5;
    localparam int EXP_COMBO_TOG = 13;
    localparam int EXP_COMBO_GS  = 9;
`endif

    score_event_serializer #(
        .FIFO_DEPTH(4), .GAP_CYCLES(8), .TICK_DIV(100), .GAME_TICKS(60), .COMBO_WINDOW(2)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_points(hit_points),
        .hit_ready(hit_ready), .score_signal(score_signal), .get_score(get_score),
        .game_end(game_end), .busy(busy), .time_left(time_left)
    );

    score_event_serializer #(
        .FIFO_DEPTH(4), .GAP_CYCLES(8), .TICK_DIV(4), .GAME_TICKS(2), .COMBO_WINDOW(2)
    ) u_short (
        .clk(clk), .rst(s_rst), .start(s_start), .hit_valid(s_hit_valid), .hit_points(s_hit_points),
        .hit_ready(s_hit_ready), .score_signal(s_score_signal), .get_score(s_get_score),
        .game_end(s_game_end), .busy(s_busy), .time_left(s_time_left)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b1; hit_valid = 1'b0; hit_points = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start = 1'b0;
    endtask

    task automatic begin_round();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic count_toggles(input int n, output int t);
        logic prev;
        prev = score_signal;
        t = 0;
        repeat (n) begin
            @(negedge clk);
            if (score_signal !== prev) t++;
            prev = score_signal;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({score_signal, get_score, game_end, busy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got sig=%0b gs=%0d end=%0b busy=%0b want all 0",
                     score_signal, get_score, game_end, busy);
        end
        checks++;
        if (hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit_ready got %0b want 0", hit_ready);
        end
        checks++;
        if (time_left !== 8'd60) begin
            errors++;
            $display("FAIL reset_time_left got %0d want 60", time_left);
        end
    endtask

    task automatic test_single_award();
        int pos[3];
        int n;
        logic prev;
        do_reset();
        begin_round();
        checks++;
        if (time_left !== 8'd60 || hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_entry got time_left=%0d ready=%0b want 60 1", time_left, hit_ready);
        end
        hit_valid = 1'b1; hit_points = 4'd3;
        @(negedge clk);
        hit_valid = 1'b0;
        prev = score_signal;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (score_signal !== prev) begin
                if (n < 3) pos[n] = k;
                n++;
            end
            prev = score_signal;
            if (k == 25) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy_in_gap got %0b want 1", busy);
                end
            end
            if (k == 26) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_drop got %0b want 0", busy);
                end
            end
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL single_toggle_count got %0d want 3", n);
        end else begin
            checks++;
            if (pos[0] !== 2 || pos[1] !== 10 || pos[2] !== 18) begin
                errors++;
                $display("FAIL single_toggle_times got %0d %0d %0d want 2 10 18", pos[0], pos[1], pos[2]);
            end
        end
        checks++;
        if (get_score !== 4'd3 || score_signal !== 1'b1) begin
            errors++;
            $display("FAIL single_final got gs=%0d sig=%0b want 3 1", get_score, score_signal);
        end
    endtask

    task automatic test_zero_award();
        int t;
        hit_valid = 1'b1; hit_points = 4'd0;
        @(negedge clk);
        hit_points = 4'd2;
        @(negedge clk);
        hit_valid = 1'b0;
        checks++;
        if (get_score !== 4'd0) begin
            errors++;
            $display("FAIL zero_get_score got %0d want 0", get_score);
        end
        @(negedge clk);
        checks++;
        if (get_score !== 4'(EXP_ZERO_PTS)) begin
            errors++;
            $display("FAIL zero_next_get_score got %0d want %0d", get_score, EXP_ZERO_PTS);
        end
        count_toggles(40, t);
        checks++;
        if (t !== EXP_ZERO_PTS) begin
            errors++;
            $display("FAIL zero_toggles got %0d want %0d", t, EXP_ZERO_PTS);
        end
    endtask

    task automatic test_fifo_full();
        int t, t2;
        logic prev;
        do_reset();
        begin_round();
        hit_valid = 1'b1; hit_points = 4'd1;
        @(negedge clk);
        hit_valid = 1'b0;
        @(negedge clk);
        prev = score_signal;
        t = 0;
        for (int i = 0; i < 5; i++) begin
            hit_valid = 1'b1; hit_points = 4'd1;
            checks++;
            if (hit_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL full_hit_ready offer %0d got %0b want %0b", i, hit_ready, (i < 4));
            end
            @(negedge clk);
            if (score_signal !== prev) t++;
            prev = score_signal;
        end
        hit_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy got %0b want 1", busy);
        end
        count_toggles(110, t2);
        checks++;
        if (t + t2 !== EXP_FULL_TOG) begin
            errors++;
            $display("FAIL full_toggle_total got %0d want %0d", t + t2, EXP_FULL_TOG);
        end
        checks++;
        if (busy !== 1'b0 || hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_drained got busy=%0b ready=%0b want 0 1", busy, hit_ready);
        end
    endtask

    task automatic test_combo();
        int t;
        do_reset();
        begin_round();
        hit_valid = 1'b1; hit_points = 4'd4;
        @(negedge clk);
        hit_points = 4'd9;
        @(negedge clk);
        hit_valid = 1'b0;
        count_toggles(200, t);
        checks++;
        if (t !== EXP_COMBO_TOG) begin
            errors++;
            $display("FAIL combo_toggles got %0d want %0d", t, EXP_COMBO_TOG);
        end
        checks++;
        if (get_score !== 4'(EXP_COMBO_GS)) begin
            errors++;
            $display("FAIL combo_get_score got %0d want %0d", get_score, EXP_COMBO_GS);
        end
    endtask

    task automatic test_round_end();
        int t;
        logic prev;
        @(negedge clk);
        s_rst = 1'b0; s_start = 1'b0; s_hit_valid = 1'b0; s_hit_points = 4'd0;
        repeat (2) @(negedge clk);
        s_rst = 1'b1;
        checks++;
        if (s_time_left !== 8'd2 || s_game_end !== 1'b0) begin
            errors++;
            $display("FAIL short_reset got time_left=%0d end=%0b want 2 0", s_time_left, s_game_end);
        end
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_hit_valid = 1'b1; s_hit_points = 4'd15;
        @(negedge clk);
        s_hit_valid = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (s_time_left !== 8'd1) begin
                    errors++;
                    $display("FAIL end_time_left_mid got %0d want 1", s_time_left);
                end
            end
            if (k == 7) begin
                checks++;
                if (s_game_end !== 1'b0 || s_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL end_before got end=%0b busy=%0b want 0 1", s_game_end, s_busy);
                end
            end
        end
        checks++;
        if (s_game_end !== 1'b1 || s_busy !== 1'b0 || s_hit_ready !== 1'b0 || s_time_left !== 8'd0) begin
            errors++;
            $display("FAIL end_entry got end=%0b busy=%0b ready=%0b time_left=%0d want 1 0 0 0",
                     s_game_end, s_busy, s_hit_ready, s_time_left);
        end
        checks++;
        if (s_get_score !== 4'd15 || s_score_signal !== 1'b1) begin
            errors++;
            $display("FAIL end_hold got gs=%0d sig=%0b want 15 1", s_get_score, s_score_signal);
        end
        prev = s_score_signal;
        t = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_score_signal !== prev) t++;
            prev = s_score_signal;
        end
        checks++;
        if (t !== 0 || s_game_end !== 1'b1) begin
            errors++;
            $display("FAIL end_quiet got toggles=%0d end=%0b want 0 1", t, s_game_end);
        end
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        checks++;
        if (s_game_end !== 1'b0 || s_time_left !== 8'd2) begin
            errors++;
            $display("FAIL restart got end=%0b time_left=%0d want 0 2", s_game_end, s_time_left);
        end
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s_time_left !== 8'd1) begin
            errors++;
            $display("FAIL start_in_run_ignored got time_left=%0d want 1", s_time_left);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_points = 4'd0;
        s_rst = 1'b1; s_start = 1'b0; s_hit_valid = 1'b0; s_hit_points = 4'd0;
        test_reset();
        test_single_award();
        test_zero_award();
        test_fifo_full();
        test_combo();
        test_round_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
